// File: rtl/backend_stage_chain_pkg.sv
// rtl/backend_stage_chain_pkg.sv - shared defaults and per-stage action encoding for the backend stage chain
//
// Purpose : parameter defaults for the chain, the register-index width and the
//           decoded next-state action of one stage register.
// Contents: DEFAULT_NUM_STAGES, DEFAULT_PAYLOAD_W, DEFAULT_DATA_W, RD_W,
//           stage_act_e (KILL > HOLD > LOAD priority outcome).
package backend_stage_chain_pkg;

    localparam int DEFAULT_NUM_STAGES = 3;
    localparam int DEFAULT_PAYLOAD_W  = 64;
    localparam int DEFAULT_DATA_W     = 32;
    localparam int RD_W               = 5;

    // Outcome of the per-stage priority decode for the coming edge.
    typedef enum logic [1:0] {
        ACT_KILL = 2'd0,   // revert or per-stage clear: slot becomes a bubble
        ACT_HOLD = 2'd1,   // stalled: keep entry, still accept a late result
        ACT_LOAD = 2'd2    // advance: take the upstream entry (or issue port)
    } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one backend stage register with kill/hold/load priority and late-result capture
//
// Purpose : holds {valid, payload, rd, data_ok, data} for one stage.
// Ports   : clk, rst             clock, synchronous active-high reset
//           flush, clr, hold     whole-chain revert, per-stage bubble, per-stage stall
//           src_*                entry presented for loading when advancing
//           res_valid, res_data  late result strobe for the entry currently held here
//           valid .. data        registered stage contents
module pipe_stage_reg
    import backend_stage_chain_pkg::*;
#(
    parameter int PAYLOAD_W = DEFAULT_PAYLOAD_W,
    parameter int DATA_W    = DEFAULT_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 clr,
    input  logic                 hold,
    input  logic                 src_valid,
    input  logic [PAYLOAD_W-1:0] src_payload,
    input  logic [RD_W-1:0]      src_rd,
    input  logic                 src_data_ok,
    input  logic [DATA_W-1:0]    src_data,
    input  logic                 res_valid,
    input  logic [DATA_W-1:0]    res_data,
    output logic                 valid,
    output logic [PAYLOAD_W-1:0] payload,
    output logic [RD_W-1:0]      rd,
    output logic                 data_ok,
    output logic [DATA_W-1:0]    data
);

    stage_act_e act;
    logic       late_hit;

    // A late result only lands on an occupied entry that is still waiting.
    assign late_hit = valid & ~data_ok & res_valid;

    always_comb begin
        act = ACT_LOAD;
        if (flush | clr) begin
            act = ACT_KILL;
        end else if (hold) begin
            act = ACT_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            payload <= '0;
            rd      <= '0;
            data_ok <= 1'b0;
            data    <= '0;
        end else begin
            unique case (act)
                ACT_KILL: begin
                    valid   <= 1'b0;
                    data_ok <= 1'b0;
                end
                ACT_HOLD: begin
                    if (late_hit) begin
                        data_ok <= 1'b1;
                        data    <= res_data;
                    end
                end
                ACT_LOAD: begin
                    valid   <= src_valid;
                    payload <= src_payload;
                    rd      <= src_rd;
                    data_ok <= src_valid & src_data_ok;
                    data    <= src_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/backend_stage_chain.sv
// rtl/backend_stage_chain.sv - in-order backend pipeline (ex, m1, m2, ...) with stall, bubble, flush and forwarding
//
// Purpose : chains NUM_STAGES pipe_stage_reg instances, derives the monotone
//           stall vector, exposes forwarding state and the retire port.
// Ports   : clk, rst                      clock, synchronous active-high reset
//           in_*                          issue port (valid/ready handshake)
//           stall_req_i, clr_vec_i        per-stage stall request / bubble insert
//           revert_i                      flush the whole chain
//           res_valid_i, res_data_i       per-stage late results
//           stall_vec_o                   effective per-stage hold
//           stage_valid_o/_payload_o      stage occupancy and payloads
//           fwd_*                         forwarding view of every stage
//           wb_*                          retire port (last stage)
module backend_stage_chain
    import backend_stage_chain_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int PAYLOAD_W  = DEFAULT_PAYLOAD_W,
    parameter int DATA_W     = DEFAULT_DATA_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [PAYLOAD_W-1:0]           in_payload_i,
    input  logic [4:0]                     in_rd_i,
    input  logic                           in_data_ok_i,
    input  logic [DATA_W-1:0]              in_data_i,
    input  logic [NUM_STAGES-1:0]          stall_req_i,
    input  logic [NUM_STAGES-1:0]          clr_vec_i,
    input  logic                           revert_i,
    input  logic [NUM_STAGES-1:0]          res_valid_i,
    input  logic [NUM_STAGES*DATA_W-1:0]   res_data_i,
    output logic [NUM_STAGES-1:0]          stall_vec_o,
    output logic [NUM_STAGES-1:0]          stage_valid_o,
    output logic [NUM_STAGES*PAYLOAD_W-1:0] stage_payload_o,
    output logic [NUM_STAGES-1:0]          fwd_valid_o,
    output logic [NUM_STAGES-1:0]          fwd_pending_o,
    output logic [NUM_STAGES*5-1:0]        fwd_rd_o,
    output logic [NUM_STAGES*DATA_W-1:0]   fwd_data_o,
    output logic                           wb_valid_o,
    output logic [4:0]                     wb_rd_o,
    output logic [DATA_W-1:0]              wb_data_o
);

    logic [NUM_STAGES-1:0]                stage_valid;
    logic [NUM_STAGES-1:0]                stage_data_ok;
    logic [NUM_STAGES-1:0][PAYLOAD_W-1:0] stage_payload;
    logic [NUM_STAGES-1:0][RD_W-1:0]      stage_rd;
    logic [NUM_STAGES-1:0][DATA_W-1:0]    stage_data;
    logic [NUM_STAGES-1:0]                stall;
    logic                                 last_wait;

    // The last stage cannot retire an entry whose result is still unknown.
    assign last_wait = stage_valid[NUM_STAGES-1] & ~stage_data_ok[NUM_STAGES-1];

    // A hold anywhere downstream blocks every stage above it.
    always_comb begin
        stall = '0;
        stall[NUM_STAGES-1] = stall_req_i[NUM_STAGES-1] | last_wait;
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            stall[i] = stall[i+1] | stall_req_i[i];
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        logic                 src_valid;
        logic [PAYLOAD_W-1:0] src_payload;
        logic [RD_W-1:0]      src_rd;
        logic                 src_data_ok;
        logic [DATA_W-1:0]    src_data;

        if (g == 0) begin : g_head
            assign src_valid   = in_valid_i & in_ready_o;
            assign src_payload = in_payload_i;
            assign src_rd      = in_rd_i;
            assign src_data_ok = in_data_ok_i;
            assign src_data    = in_data_i;
        end else begin : g_body
            logic up_late;
            // An upstream stage that is itself held must not be copied down,
            // otherwise the entry would be duplicated; a bubble is loaded instead.
            assign src_valid   = stage_valid[g-1] & ~stall[g-1];
            assign src_payload = stage_payload[g-1];
            assign src_rd      = stage_rd[g-1];
            // A late result arriving on the edge the entry moves is carried along.
            assign up_late     = ~stage_data_ok[g-1] & res_valid_i[g-1];
            assign src_data_ok = stage_data_ok[g-1] | res_valid_i[g-1];
            assign src_data    = up_late ? res_data_i[(g-1)*DATA_W +: DATA_W] : stage_data[g-1];
        end

        pipe_stage_reg #(
            .PAYLOAD_W (PAYLOAD_W),
            .DATA_W    (DATA_W)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .flush       (revert_i),
            .clr         (clr_vec_i[g]),
            .hold        (stall[g]),
            .src_valid   (src_valid),
            .src_payload (src_payload),
            .src_rd      (src_rd),
            .src_data_ok (src_data_ok),
            .src_data    (src_data),
            .res_valid   (res_valid_i[g]),
            .res_data    (res_data_i[g*DATA_W +: DATA_W]),
            .valid       (stage_valid[g]),
            .payload     (stage_payload[g]),
            .rd          (stage_rd[g]),
            .data_ok     (stage_data_ok[g]),
            .data        (stage_data[g])
        );

        // x0 never forwards: its value is architecturally fixed.
        assign fwd_valid_o[g]   = stage_valid[g] &  stage_data_ok[g] & (stage_rd[g] != '0);
        assign fwd_pending_o[g] = stage_valid[g] & ~stage_data_ok[g] & (stage_rd[g] != '0);
    end

    assign in_ready_o      = ~stall[0];
    assign stall_vec_o     = stall;
    assign stage_valid_o   = stage_valid;
    assign stage_payload_o = stage_payload;
    assign fwd_rd_o        = stage_rd;
    assign fwd_data_o      = stage_data;
    assign wb_valid_o      = stage_valid[NUM_STAGES-1] & ~stall[NUM_STAGES-1];
    assign wb_rd_o         = stage_rd[NUM_STAGES-1];
    assign wb_data_o       = stage_data[NUM_STAGES-1];

endmodule

// File: tb/tb_backend_stage_chain.sv
// tb/tb_backend_stage_chain.sv - scoreboard bench for backend_stage_chain
module tb_backend_stage_chain;

    localparam int NS = 3;
    localparam int PW = 64;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [PW-1:0]     in_payload_i;
    logic [4:0]        in_rd_i;
    logic              in_data_ok_i;
    logic [DW-1:0]     in_data_i;
    logic [NS-1:0]     stall_req_i;
    logic [NS-1:0]     clr_vec_i;
    logic              revert_i;
    logic [NS-1:0]     res_valid_i;
    logic [NS*DW-1:0]  res_data_i;
    logic [NS-1:0]     stall_vec_o;
    logic [NS-1:0]     stage_valid_o;
    logic [NS*PW-1:0]  stage_payload_o;
    logic [NS-1:0]     fwd_valid_o;
    logic [NS-1:0]     fwd_pending_o;
    logic [NS*5-1:0]   fwd_rd_o;
    logic [NS*DW-1:0]  fwd_data_o;
    logic              wb_valid_o;
    logic [4:0]        wb_rd_o;
    logic [DW-1:0]     wb_data_o;

    backend_stage_chain #(.NUM_STAGES(NS), .PAYLOAD_W(PW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_payload_i(in_payload_i),
        .in_rd_i(in_rd_i), .in_data_ok_i(in_data_ok_i), .in_data_i(in_data_i),
        .stall_req_i(stall_req_i), .clr_vec_i(clr_vec_i), .revert_i(revert_i),
        .res_valid_i(res_valid_i), .res_data_i(res_data_i),
        .stall_vec_o(stall_vec_o), .stage_valid_o(stage_valid_o), .stage_payload_o(stage_payload_o),
        .fwd_valid_o(fwd_valid_o), .fwd_pending_o(fwd_pending_o), .fwd_rd_o(fwd_rd_o),
        .fwd_data_o(fwd_data_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Retire monitor: every retire must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wb_valid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h, expected no retire", wb_rd_o, wb_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_rd", 64'(wb_rd_o), 64'(mon_e.rd));
                check("wb_data", 64'(wb_data_o), 64'(mon_e.data));
            end
        end
    end

    task automatic idle_inputs();
        in_valid_i   = 1'b0;
        in_payload_i = '0;
        in_rd_i      = '0;
        in_data_ok_i = 1'b0;
        in_data_i    = '0;
        stall_req_i  = '0;
        clr_vec_i    = '0;
        revert_i     = 1'b0;
        res_valid_i  = '0;
        res_data_i   = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) next_cycle();
    endtask

    task automatic issue(input logic [4:0] rd, input logic ok, input logic [DW-1:0] d, input logic retires);
        exp_t e;
        in_valid_i   = 1'b1;
        in_rd_i      = rd;
        in_data_ok_i = ok;
        in_data_i    = d;
        in_payload_i = {27'd0, rd, d};
        if (retires) begin
            e.rd   = rd;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        check("rst_stall", 64'(stall_vec_o), 64'd0);
        check("rst_valid", 64'(stage_valid_o), 64'd0);
        check("rst_fwd_valid", 64'(fwd_valid_o), 64'd0);
        check("rst_fwd_pending", 64'(fwd_pending_o), 64'd0);
        check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        next_cycle();

        // Latency: issue in cycle 0 retires in cycle 3.
        issue(5'd5, 1'b1, 32'h1234, 1'b1);
        next_cycle();
        @(negedge clk);
        check("lat_fwd_c1", 64'(fwd_valid_o), 64'b001);
        check("lat_fwd_rd_c1", 64'(fwd_rd_o[4:0]), 64'd5);
        next_cycle();
        @(negedge clk);
        check("lat_wb_c2", 64'(wb_valid_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check("lat_wb_c3", 64'(wb_valid_o), 64'd1);
        drain(4);

        // Late result at the last stage.
        issue(5'd7, 1'b0, 32'h0, 1'b0);
        begin
            exp_t e;
            e.rd = 5'd7;
            e.data = 32'hBEEF;
            exp_q.push_back(e);
        end
        drain(3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("late_stall", 64'(stall_vec_o), 64'b111);
            check("late_ready", 64'(in_ready_o), 64'd0);
            next_cycle();
        end
        res_valid_i = 3'b100;
        res_data_i[95:64] = 32'hBEEF;
        @(negedge clk);
        check("late_pending", 64'(fwd_pending_o), 64'b100);
        check("late_no_wb", 64'(wb_valid_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check("late_wb", 64'(wb_valid_o), 64'd1);
        check("late_fwd_valid", 64'(fwd_valid_o), 64'b100);
        check("late_stall_clear", 64'(stall_vec_o), 64'd0);
        drain(4);

        // Mid-chain stall for two cycles.
        issue(5'd1, 1'b1, 32'hA1, 1'b1);
        next_cycle();
        issue(5'd2, 1'b1, 32'hB2, 1'b1);
        next_cycle();
        issue(5'd3, 1'b1, 32'hC3, 1'b1);
        next_cycle();
        stall_req_i = 3'b010;
        @(negedge clk);
        check("mid_stall_vec", 64'(stall_vec_o), 64'b011);
        check("mid_ready", 64'(in_ready_o), 64'd0);
        check("mid_drain_wb", 64'(wb_valid_o), 64'd1);
        next_cycle();
        stall_req_i = 3'b010;
        @(negedge clk);
        check("mid_bubble", 64'(stage_valid_o), 64'b011);
        check("mid_no_wb", 64'(wb_valid_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check("mid_release", 64'(stage_valid_o), 64'b011);
        next_cycle();
        @(negedge clk);
        check("mid_advance", 64'(stage_valid_o), 64'b110);
        drain(4);

        // Revert with a full chain and a same-cycle issue.
        issue(5'd4, 1'b1, 32'hD4, 1'b1);
        next_cycle();
        issue(5'd5, 1'b1, 32'hE5, 1'b0);
        next_cycle();
        issue(5'd6, 1'b1, 32'hF6, 1'b0);
        next_cycle();
        check("rev_full", 64'(stage_valid_o), 64'b111);
        issue(5'd10, 1'b1, 32'h77, 1'b0);
        revert_i = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rev_empty", 64'(stage_valid_o), 64'd0);
        check("rev_no_wb", 64'(wb_valid_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check("rev_dropped", 64'(stage_valid_o), 64'd0);
        drain(3);

        // Bubble insertion in stage 1 while the tail is stalled.
        issue(5'd11, 1'b1, 32'h11, 1'b1);
        next_cycle();
        issue(5'd12, 1'b1, 32'h12, 1'b0);
        next_cycle();
        issue(5'd13, 1'b1, 32'h13, 1'b1);
        next_cycle();
        stall_req_i = 3'b100;
        clr_vec_i   = 3'b010;
        @(negedge clk);
        check("clr_stall_vec", 64'(stall_vec_o), 64'b111);
        next_cycle();
        stall_req_i = 3'b100;
        @(negedge clk);
        check("clr_valid", 64'(stage_valid_o), 64'b101);
        check("clr_rd0", 64'(fwd_rd_o[4:0]), 64'd13);
        check("clr_rd2", 64'(fwd_rd_o[14:10]), 64'd11);
        next_cycle();
        @(negedge clk);
        check("clr_wb", 64'(wb_valid_o), 64'd1);
        drain(4);

        // rd = 0 never forwards but still retires.
        issue(5'd0, 1'b1, 32'h55, 1'b1);
        next_cycle();
        @(negedge clk);
        check("x0_valid_c1", 64'(stage_valid_o), 64'b001);
        check("x0_fwd_c1", 64'(fwd_valid_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check("x0_fwd_c2", 64'(fwd_valid_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check("x0_fwd_c3", 64'(fwd_valid_o), 64'd0);
        check("x0_wb", 64'(wb_valid_o), 64'd1);
        drain(4);

        // Reset while an entry waits for its result at the last stage.
        issue(5'd9, 1'b0, 32'h0, 1'b0);
        drain(3);
        @(negedge clk);
        check("rs_stall", 64'(stall_vec_o), 64'b111);
        check("rs_pending", 64'(fwd_pending_o), 64'b100);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rs_valid", 64'(stage_valid_o), 64'd0);
        check("rs_stall_clear", 64'(stall_vec_o), 64'd0);
        check("rs_ready", 64'(in_ready_o), 64'd1);
        check("rs_pending_clear", 64'(fwd_pending_o), 64'd0);
        drain(4);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
